// File: rtl/up_dn_counter.sv
// Loadable saturating up/down counter with top/bottom flags.
// Control priority is LOAD > Down > Up; the count never wraps at either end.
module up_dn_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] IN,
    input  logic             LOAD,
    input  logic             Up,
    input  logic             Down,
    output logic [WIDTH-1:0] Counter,
    output logic             High,
    output logic             Low
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // Flags decode only the registered count, so they carry no input-to-output path.
    assign High = (Counter == MAX_VAL);
    assign Low  = (Counter == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Counter <= '0;
        end else if (LOAD) begin
            Counter <= IN;
        end else if (Down) begin
            if (!Low) begin
                Counter <= Counter - ONE;
            end
        end else if (Up) begin
            if (!High) begin
                Counter <= Counter + ONE;
            end
        end
    end

endmodule

// File: tb/tb_up_dn_counter.sv
// Self-checking bench for up_dn_counter: directed plan plus randomized traffic
// compared against an integer reference model.
module tb_up_dn_counter;

    localparam int WIDTH = 5;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_val;
    logic             load;
    logic             up;
    logic             down;
    logic [WIDTH-1:0] counter;
    logic             high;
    logic             low;

    int n_checks = 0;
    int n_fail   = 0;
    int model    = 0;

    up_dn_counter #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .IN      (in_val),
        .LOAD    (load),
        .Up      (up),
        .Down    (down),
        .Counter (counter),
        .High    (high),
        .Low     (low)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, 32'(counter), 32'(model));
        check({tag, ".high"},  32'(high),    32'(model == MAXV));
        check({tag, ".low"},   32'(low),     32'(model == 0));
    endtask

    // Reference: one clock applies the highest-priority request, clamped to [0, MAXV].
    task automatic model_edge(input bit ld, input bit dn, input bit upv, input int inv);
        if (ld)       model = inv;
        else if (dn)  model = (model == 0)    ? 0    : model - 1;
        else if (upv) model = (model == MAXV) ? MAXV : model + 1;
    endtask

    task automatic step(input string tag, input bit ld, input bit dn, input bit upv, input int inv);
        load   = ld;
        down   = dn;
        up     = upv;
        in_val = WIDTH'(inv);
        @(posedge clk);
        model_edge(ld, dn, upv, inv);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model = 0;
        #1;
        check_all({tag, ".async"});
        load   = 1'b1;
        in_val = WIDTH'(9);
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        in_val = '0;
        load   = 1'b0;
        up     = 1'b0;
        down   = 1'b0;
        #1;
        check_all("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-count from 17, then release with no controls.
        step("ld17", 1, 0, 0, 17);
        check("ld17.val", 32'(counter), 32'd17);
        async_reset("rst17");
        step("post_rst", 0, 0, 0, 0);
        check("post_rst.zero", 32'(counter), 32'd0);

        // Load and load-over-everything.
        step("ld10", 1, 0, 0, 10);
        check("ld10.val", 32'(counter), 32'd10);
        step("ld_prio", 1, 1, 1, 10);
        check("ld_prio.val", 32'(counter), 32'd10);

        // Down, Down-over-Up, hold.
        repeat (3) step("down", 0, 1, 0, 0);
        check("down.val", 32'(counter), 32'd7);
        repeat (4) step("dn_over_up", 0, 1, 1, 0);
        check("dn_over_up.val", 32'(counter), 32'd3);
        repeat (4) step("hold", 0, 0, 0, 0);
        check("hold.val", 32'(counter), 32'd3);

        // Bottom saturation.
        repeat (5) step("low_sat", 0, 1, 0, 0);
        check("low_sat.val", 32'(counter), 32'd0);
        check("low_sat.flag", 32'(low), 32'd1);

        // Top saturation.
        repeat (33) step("high_sat", 0, 0, 1, 0);
        check("high_sat.val", 32'(counter), 32'(MAXV));
        check("high_sat.flag", 32'(high), 32'd1);

        // Boundary loads.
        step("ld_max", 1, 0, 0, MAXV);
        step("up_at_max", 0, 0, 1, 0);
        check("up_at_max.val", 32'(counter), 32'(MAXV));
        step("ld_zero", 1, 0, 0, 0);
        step("up_from0", 0, 0, 1, 0);
        check("up_from0.val", 32'(counter), 32'd1);
        check("up_from0.low", 32'(low), 32'd0);

        // Randomized traffic, biased toward counting so both limits get exercised.
        for (int i = 0; i < 600; i++) begin
            int r;
            int inv;
            bit ld, dn, upv;
            r   = int'($urandom_range(0, 99));
            inv = int'($urandom_range(0, MAXV));
            ld  = (r < 6);
            if ((i / 80) % 2 == 0) begin
                upv = ($urandom_range(0, 9) < 8);
                dn  = ($urandom_range(0, 9) < 2);
            end else begin
                upv = ($urandom_range(0, 9) < 4);
                dn  = ($urandom_range(0, 9) < 7);
            end
            if (r == 99) async_reset("rnd_rst");
            step("rnd", ld, dn, upv, inv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
